bd_out_handshaker: RTL and testbench
====================================

Name: bd_out_handshaker

Overview:
- Sits directly downstream of the core's BD_out channel, after the core-side output FIFO.
- Consumes one 21-bit encoded BD word per channel transfer and drives the BD chip's asynchronous 4-phase bundled-data input port: data, then req rise, ack rise, req fall, ack fall.
- Synchronizes the asynchronous ack from the chip and enforces a programmable data-setup time before req rises.
- Suppresses all traffic while BD is held in pReset.

Parameters:
N, 21, width of encoded BD word (matches BD_out channel width)
NSync, 2, number of synchronizer flops on bd_ack (>=2)
NSetup, 2, clk cycles bd_data is held stable before bd_req rises (>=1)
Ncount, 16, width of the sent-word counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (reset==0 resets the block)
BD_out_d  in  N  channel data from core
BD_out_v  in  1  channel valid
BD_out_a  out  1  channel ack; a transfer occurs on a clk edge where BD_out_v && BD_out_a
pReset  in  1  BD chip reset from core config; high = BD in reset
bd_data  out  N  bundled data to BD chip (registered)
bd_req  out  1  4-phase request to BD chip (registered)
bd_ack  in  1  4-phase acknowledge from BD chip, asynchronous to clk
busy  out  1  high in any state other than IDLE
words_sent  out  Ncount  count of completed 4-phase cycles, wraps

Behaviour:
- Reset (reset==0, asynchronous) values:
  - state=IDLE; bd_req=0; bd_data=0; words_sent=0.
  - Synchronizer flops = 0; setup counter = 0.
  - BD_out_a=0 while reset is low.
- ack_s = bd_ack delayed through NSync flops. All FSM decisions use ack_s only, never raw bd_ack.
- BD_out_a is combinational: BD_out_a = (state==IDLE) && !pReset && !ack_s.
- FSM states and transitions:
  - IDLE:
    - On transfer (BD_out_v && BD_out_a): bd_data <= BD_out_d; counter <= NSetup-1; next state SETUP.
    - bd_data holds its last value otherwise.
  - SETUP:
    - bd_req=0. Counter decrements each cycle.
    - When counter==0: bd_req <= 1; next state REQ.
    - Result: bd_req rises exactly NSetup edges after the capture edge.
  - REQ:
    - bd_req=1, bd_data stable.
    - When ack_s==1: bd_req <= 0; next state RELEASE.
  - RELEASE:
    - bd_req=0, bd_data unchanged.
    - When ack_s==0: words_sent <= words_sent+1 (mod 2^Ncount); next state IDLE.
- Throughput: at most one word per full 4-phase cycle.
  - Minimum, with the chip acking instantly: NSetup + 2*NSync + 2 cycles per word.
- bd_data changes only on the capture edge in IDLE. It is never modified while bd_req=1 or while ack_s=1.
- pReset behaviour:
  - pReset high in IDLE: BD_out_a=0 and no capture. The channel back-pressures; the upstream FIFO holds its words.
  - pReset rises in SETUP: the captured word is dropped, bd_req stays 0, next state IDLE. The word is not counted.
  - pReset rises in REQ: bd_req <= 0, next state RELEASE. The cycle completes normally on ack_s==0 and is counted only if it reaches IDLE via RELEASE.
  - pReset in RELEASE: no effect.
- ack_s==1 while in IDLE (spurious or stale ack): no new capture until ack_s returns to 0.
- BD_out_v with BD_out_a low: no capture. Upstream must hold d and v stable (standard channel rule).
- Reset asserted mid-cycle: everything returns to reset values immediately; bd_req drops asynchronously.
- busy = (state != IDLE).

Test Plan:
- Single word, NSetup=2, NSync=2, chip model acks 3 cycles after req rise and drops ack 3 cycles after req fall. Drive BD_out_d=21'h1A5A5A with v=1.
  - Transfer on edge 0; bd_data=21'h1A5A5A.
  - bd_req rises at edge 2 and falls after ack_s goes high.
  - words_sent=1; busy low afterwards.
  - bd_data never changes while bd_req=1.
- Back-to-back: 8 words 0..7 queued with v held high.
  - Chip receives 0..7 in order, with exactly one req pulse per word; words_sent=8.
  - BD_out_a is never high outside IDLE.
- Setup timing: NSetup=5.
  - Exactly 5 clk edges between the capture edge and the bd_req rise, for every word.
- pReset:
  - Held high with v=1: BD_out_a stays 0 for 100 cycles, no req.
  - Pulsed during SETUP: no req, words_sent unchanged, next word accepted after pReset falls.
  - Pulsed during REQ: req drops, block returns to IDLE only after ack falls.
- Stale ack: bd_ack held high at reset release.
  - No transfer until bd_ack goes low, then the first word proceeds normally.
  - Metastability: bd_ack toggling 1 ns from clk edges must not skip the RELEASE state.
- Wrap and reset:
  - Ncount=4: after 17 words, words_sent=1.
  - reset driven low while in REQ: bd_req=0 and state IDLE immediately (asynchronously), bd_data=0.

Source files
------------

// File: rtl/bd_out_handshaker.sv
// Bridges the core's BD_out channel to the BD chip's asynchronous 4-phase
// bundled-data input: capture word, hold data for a setup time, then req/ack.
module bd_out_handshaker #(
  parameter int N      = 21,
  parameter int NSync  = 2,
  parameter int NSetup = 2,
  parameter int Ncount = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      BD_out_d,
  input  logic              BD_out_v,
  output logic              BD_out_a,
  input  logic              pReset,
  output logic [N-1:0]      bd_data,
  output logic              bd_req,
  input  logic              bd_ack,
  output logic              busy,
  output logic [Ncount-1:0] words_sent,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] REQ     = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam int CW = (NSetup > 1) ? $clog2(NSetup) : 1;

  logic [1:0]       state;
  logic [NSync-1:0] ack_sync;
  logic             ack_s;
  logic [CW-1:0]    setup_cnt;
  logic             xfer;

  // bd_ack is asynchronous; only the synchronized copy ever steers the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NSync-2:0], bd_ack};
    end
  end

  assign ack_s = ack_sync[NSync-1];

  // Channel handshake: a word moves on any clk edge where BD_out_v and
  // BD_out_a are both high; the producer holds BD_out_d/BD_out_v until then.
  assign BD_out_a  = reset && (state == IDLE) && !pReset && !ack_s;
  assign xfer      = BD_out_v && BD_out_a;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bd_req     <= 1'b0;
      bd_data    <= '0;
      words_sent <= '0;
      setup_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            bd_data   <= BD_out_d;
            setup_cnt <= CW'(NSetup - 1);
            state     <= SETUP;
          end
        end
        SETUP: begin
          // A pReset here drops the captured word before the chip sees req.
          if (pReset) begin
            state <= IDLE;
          end else if (setup_cnt == '0) begin
            bd_req <= 1'b1;
            state  <= REQ;
          end else begin
            setup_cnt <= setup_cnt - 1'b1;
          end
        end
        REQ: begin
          if (ack_s || pReset) begin
            bd_req <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          // Wait for the chip to finish the return-to-zero phase.
          if (!ack_s) begin
            words_sent <= words_sent + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bd_out_handshaker.sv
// Bench for bd_out_handshaker: two instances (NSetup=2/Ncount=16 and
// NSetup=5/Ncount=4), a reactive 4-phase chip model, and a word scoreboard.
module tb_bd_out_handshaker;
  localparam int N = 21;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_a[2]  = '{1'b0, 1'b0};
  logic [N-1:0] d_a[2]    = '{'0, '0};
  logic         v_a[2]    = '{1'b0, 1'b0};
  logic         prst_a[2] = '{1'b0, 1'b0};
  logic         a_a[2];
  logic [N-1:0] data_a[2];
  logic         req_a[2];
  logic         ack_a[2];
  logic         busy_a[2];
  logic [1:0]   st_a[2];
  logic [15:0]  ws0;
  logic [3:0]   ws1;

  logic chip_auto[2] = '{1'b1, 1'b1};
  logic chip_ack[2]  = '{1'b0, 1'b0};
  logic man_ack[2]   = '{1'b0, 1'b0};
  int   ack_dly[2]   = '{3, 1};

  logic [N-1:0] rx_mem[2][128];
  int rx_n[2]      = '{0, 0};
  int cap_cyc[2]   = '{0, 0};
  int cap_n[2]     = '{0, 0};
  int lat_mem[2][128];
  int lat_n[2]     = '{0, 0};
  int pulse_n[2]   = '{0, 0};
  int a_viol[2]    = '{0, 0};
  int data_viol[2] = '{0, 0};
  int skip_viol[2] = '{0, 0};

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  int ws_exp[2] = '{0, 0};

  bd_out_handshaker #(.N(N), .NSync(2), .NSetup(2), .Ncount(16)) dut0 (
    .clk(clk), .reset(rst_a[0]), .BD_out_d(d_a[0]), .BD_out_v(v_a[0]),
    .BD_out_a(a_a[0]), .pReset(prst_a[0]), .bd_data(data_a[0]),
    .bd_req(req_a[0]), .bd_ack(ack_a[0]), .busy(busy_a[0]),
    .words_sent(ws0), .state_dbg(st_a[0]));

  bd_out_handshaker #(.N(N), .NSync(2), .NSetup(5), .Ncount(4)) dut1 (
    .clk(clk), .reset(rst_a[1]), .BD_out_d(d_a[1]), .BD_out_v(v_a[1]),
    .BD_out_a(a_a[1]), .pReset(prst_a[1]), .bd_data(data_a[1]),
    .bd_req(req_a[1]), .bd_ack(ack_a[1]), .busy(busy_a[1]),
    .words_sent(ws1), .state_dbg(st_a[1]));

  for (genvar g = 0; g < 2; g++) begin : g_mon
    int cnt = 0;
    logic req_q = 1'b0;
    logic [1:0] st_q = 2'd0;
    logic [N-1:0] data_q = '0;

    assign ack_a[g] = chip_auto[g] ? chip_ack[g] : man_ack[g];

    // Chip model: ack follows req ack_dly edges later; word logged on ack rise.
    always @(posedge clk) begin
      if (rst_a[g] && v_a[g] && a_a[g]) begin
        cap_cyc[g] = cyc;
        cap_n[g]++;
      end
      if (!chip_auto[g]) begin
        chip_ack[g] <= 1'b0;
        cnt = 0;
      end else if (req_a[g] != chip_ack[g]) begin
        if (cnt >= ack_dly[g] - 1) begin
          chip_ack[g] <= req_a[g];
          cnt = 0;
          if (req_a[g]) begin
            rx_mem[g][rx_n[g] % 128] = data_a[g];
            rx_n[g]++;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end

    always @(negedge clk) begin
      if (rst_a[g]) begin
        if (req_a[g] && !req_q) begin
          pulse_n[g]++;
          lat_mem[g][lat_n[g] % 128] = (cyc - 1) - cap_cyc[g];
          lat_n[g]++;
        end
        if (busy_a[g] && a_a[g]) a_viol[g]++;
        if ((req_a[g] || req_q) && data_a[g] !== data_q) data_viol[g]++;
        if (st_q == S_REQ && st_a[g] == S_IDLE) skip_viol[g]++;
      end
      req_q  = req_a[g];
      st_q   = st_a[g];
      data_q = data_a[g];
    end
  end

  function automatic int get_ws(input int i);
    return (i == 0) ? int'(ws0) : int'(ws1);
  endfunction

  function automatic int wrap_of(input int i);
    return (i == 0) ? 65536 : 16;
  endfunction

  task automatic sync_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int i, input logic [N-1:0] w, input bit hold);
    bit ok = 0;
    d_a[i] = w;
    v_a[i] = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk);
      if (a_a[i]) ok = 1;
    end
    #1;
    if (!hold) v_a[i] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL xfer_timeout dut%0d word %h not accepted in 300 cycles", i, w);
    end
  endtask

  task automatic wait_idle(input int i);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (!busy_a[i]) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout dut%0d busy still 1 after 400 cycles", i);
    end
  endtask

  task automatic wait_req(input int i, input logic val);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_a[i] === val) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_timeout dut%0d bd_req never became %0b", i, val);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b0;
      v_a[i]   = 1'b1;
      d_a[i]   = N'($urandom());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_a[i] !== 1'b0 || data_a[i] !== '0 || get_ws(i) !== 0 ||
          busy_a[i] !== 1'b0 || a_a[i] !== 1'b0 || st_a[i] !== S_IDLE) begin
        errors++;
        $display("FAIL reset_values dut%0d req=%b data=%h ws=%0d busy=%b a=%b st=%0d want all 0",
                 i, req_a[i], data_a[i], get_ws(i), busy_a[i], a_a[i], st_a[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      v_a[i]    = 1'b0;
      rst_a[i]  = 1'b1;
      ws_exp[i] = 0;
    end
  endtask

  task automatic test_single();
    logic [N-1:0] w = 21'h1A5A5A;
    int rb = rx_n[0];
    int pb = pulse_n[0];
    int db = data_viol[0];
    ack_dly[0] = 3;
    sync_clk();
    xfer(0, w, 1'b0);
    @(negedge clk);
    checks++;
    if (data_a[0] !== w) begin
      errors++;
      $display("FAIL single_capture bd_data=%h want %h", data_a[0], w);
    end
    wait_idle(0);
    ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
    checks++;
    if (lat_mem[0][(lat_n[0] - 1) % 128] !== 2) begin
      errors++;
      $display("FAIL single_setup latency=%0d want 2", lat_mem[0][(lat_n[0] - 1) % 128]);
    end
    checks++;
    if (rx_n[0] - rb !== 1 || rx_mem[0][rb % 128] !== w) begin
      errors++;
      $display("FAIL single_rx count=%0d word=%h want 1 %h", rx_n[0] - rb, rx_mem[0][rb % 128], w);
    end
    checks++;
    if (get_ws(0) !== ws_exp[0] || busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done ws=%0d busy=%b want %0d 0", get_ws(0), busy_a[0], ws_exp[0]);
    end
    checks++;
    if (pulse_n[0] - pb !== 1 || data_viol[0] !== db) begin
      errors++;
      $display("FAIL single_req pulses=%0d data_changes=%0d want 1 0", pulse_n[0] - pb, data_viol[0] - db);
    end
  endtask

  task automatic run_words(input int i, input int n, input bit rnd, input int setup, input string name);
    int rb = rx_n[i];
    int lb = lat_n[i];
    int pb = pulse_n[i];
    int ab = a_viol[i];
    int db = data_viol[i];
    logic [N-1:0] w;
    exp_q.delete();
    sync_clk();
    for (int k = 0; k < n; k++) begin
      w = rnd ? N'($urandom()) : N'(k);
      if (rnd) ack_dly[i] = $urandom_range(1, 6);
      exp_q.push_back(w);
      xfer(i, w, (k < n - 1));
      if (rnd) repeat ($urandom_range(0, 3)) sync_clk();
      ws_exp[i] = (ws_exp[i] + 1) % wrap_of(i);
    end
    wait_idle(i);
    checks++;
    if (rx_n[i] - rb !== n || pulse_n[i] - pb !== n) begin
      errors++;
      $display("FAIL %s_count rx=%0d pulses=%0d want %0d", name, rx_n[i] - rb, pulse_n[i] - pb, n);
    end
    for (int k = 0; k < n; k++) begin
      w = exp_q.pop_front();
      checks++;
      if (rx_mem[i][(rb + k) % 128] !== w) begin
        errors++;
        $display("FAIL %s_word[%0d] got %h want %h", name, k, rx_mem[i][(rb + k) % 128], w);
      end
      checks++;
      if (lat_mem[i][(lb + k) % 128] !== setup) begin
        errors++;
        $display("FAIL %s_setup[%0d] latency=%0d want %0d", name, k, lat_mem[i][(lb + k) % 128], setup);
      end
    end
    checks++;
    if (get_ws(i) !== ws_exp[i]) begin
      errors++;
      $display("FAIL %s_ws got %0d want %0d", name, get_ws(i), ws_exp[i]);
    end
    checks++;
    if (a_viol[i] !== ab || data_viol[i] !== db) begin
      errors++;
      $display("FAIL %s_rules a_outside_idle=%0d data_changes=%0d want 0 0", name, a_viol[i] - ab, data_viol[i] - db);
    end
  endtask

  task automatic test_preset_hold();
    int viol = 0;
    int pb = pulse_n[0];
    int cb = cap_n[0];
    int rb = rx_n[0];
    logic [N-1:0] w = N'($urandom());
    sync_clk();
    prst_a[0] = 1'b1;
    d_a[0] = w;
    v_a[0] = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (a_a[0] !== 1'b0) viol++;
    end
    checks++;
    if (viol !== 0 || pulse_n[0] !== pb || cap_n[0] !== cb) begin
      errors++;
      $display("FAIL preset_hold a_high=%0d pulses=%0d captures=%0d want 0 0 0", viol, pulse_n[0] - pb, cap_n[0] - cb);
    end
    sync_clk();
    prst_a[0] = 1'b0;
    xfer(0, w, 1'b0);
    wait_idle(0);
    ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
    checks++;
    if (rx_mem[0][rb % 128] !== w || get_ws(0) !== ws_exp[0]) begin
      errors++;
      $display("FAIL preset_hold_release word=%h ws=%0d want %h %0d", rx_mem[0][rb % 128], get_ws(0), w, ws_exp[0]);
    end
  endtask

  task automatic test_preset_setup();
    logic [N-1:0] w1 = N'($urandom());
    logic [N-1:0] w2 = N'($urandom());
    int pb = pulse_n[0];
    int rb = rx_n[0];
    sync_clk();
    xfer(0, w1, 1'b0);
    prst_a[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL preset_setup_abort busy=%b want 0", busy_a[0]);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (pulse_n[0] !== pb || get_ws(0) !== ws_exp[0]) begin
      errors++;
      $display("FAIL preset_setup_drop pulses=%0d ws=%0d want 0 %0d", pulse_n[0] - pb, get_ws(0), ws_exp[0]);
    end
    sync_clk();
    prst_a[0] = 1'b0;
    xfer(0, w2, 1'b0);
    wait_idle(0);
    ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
    checks++;
    if (rx_n[0] - rb !== 1 || rx_mem[0][rb % 128] !== w2 || get_ws(0) !== ws_exp[0]) begin
      errors++;
      $display("FAIL preset_setup_next rx=%0d word=%h ws=%0d want 1 %h %0d",
               rx_n[0] - rb, rx_mem[0][rb % 128], get_ws(0), w2, ws_exp[0]);
    end
  endtask

  task automatic test_preset_req();
    int bad = 0;
    chip_auto[0] = 1'b0;
    man_ack[0]   = 1'b0;
    sync_clk();
    xfer(0, N'($urandom()), 1'b0);
    wait_req(0, 1'b1);
    sync_clk();
    man_ack[0] = 1'b1;
    sync_clk();
    prst_a[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_a[0] !== 1'b0 || st_a[0] !== S_RELEASE) begin
      errors++;
      $display("FAIL preset_req_drop req=%b state=%0d want 0 %0d", req_a[0], st_a[0], S_RELEASE);
    end
    repeat (5) begin
      @(negedge clk);
      if (busy_a[0] !== 1'b1 || req_a[0] !== 1'b0 || a_a[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || get_ws(0) !== ws_exp[0]) begin
      errors++;
      $display("FAIL preset_req_hold bad_cycles=%0d ws=%0d want 0 %0d", bad, get_ws(0), ws_exp[0]);
    end
    sync_clk();
    man_ack[0] = 1'b0;
    wait_idle(0);
    ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
    checks++;
    if (get_ws(0) !== ws_exp[0]) begin
      errors++;
      $display("FAIL preset_req_count ws=%0d want %0d", get_ws(0), ws_exp[0]);
    end
    prst_a[0] = 1'b0;
    chip_auto[0] = 1'b1;
  endtask

  task automatic test_meta();
    int sb = skip_viol[0];
    chip_auto[0] = 1'b0;
    man_ack[0]   = 1'b0;
    sync_clk();
    for (int k = 0; k < 6; k++) begin
      xfer(0, N'($urandom()), 1'b0);
      wait_req(0, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      if (k % 2 == 1) #1; else #9;
      man_ack[0] = 1'b1;
      wait_req(0, 1'b0);
      @(posedge clk);
      if (k % 2 == 0) #1; else #9;
      man_ack[0] = 1'b0;
      wait_idle(0);
      ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
      checks++;
      if (get_ws(0) !== ws_exp[0]) begin
        errors++;
        $display("FAIL meta_ws[%0d] got %0d want %0d", k, get_ws(0), ws_exp[0]);
      end
      sync_clk();
    end
    checks++;
    if (skip_viol[0] !== sb) begin
      errors++;
      $display("FAIL meta_release_skipped count=%0d want 0", skip_viol[0] - sb);
    end
    chip_auto[0] = 1'b1;
  endtask

  task automatic test_stale_ack();
    int cb;
    int rb = rx_n[0];
    int bad = 0;
    logic [N-1:0] w = N'($urandom());
    chip_auto[0] = 1'b0;
    man_ack[0]   = 1'b1;
    rst_a[0]     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a[0]  = 1'b1;
    ws_exp[0] = 0;
    // The stale ack is visible to the FSM only once it crosses the synchronizer.
    repeat (3) sync_clk();
    cb = cap_n[0];
    d_a[0] = w;
    v_a[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (a_a[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || cap_n[0] !== cb) begin
      errors++;
      $display("FAIL stale_ack a_high=%0d captures=%0d want 0 0", bad, cap_n[0] - cb);
    end
    sync_clk();
    man_ack[0]   = 1'b0;
    chip_auto[0] = 1'b1;
    xfer(0, w, 1'b0);
    wait_idle(0);
    ws_exp[0] = (ws_exp[0] + 1) % wrap_of(0);
    checks++;
    if (rx_mem[0][rb % 128] !== w || get_ws(0) !== ws_exp[0] || lat_mem[0][(lat_n[0] - 1) % 128] !== 2) begin
      errors++;
      $display("FAIL stale_ack_first word=%h ws=%0d lat=%0d want %h %0d 2",
               rx_mem[0][rb % 128], get_ws(0), lat_mem[0][(lat_n[0] - 1) % 128], w, ws_exp[0]);
    end
  endtask

  task automatic test_reset_mid();
    chip_auto[0] = 1'b0;
    man_ack[0]   = 1'b0;
    sync_clk();
    xfer(0, N'($urandom()), 1'b0);
    wait_req(0, 1'b1);
    @(posedge clk);
    #3;
    rst_a[0] = 1'b0;
    #1;
    checks++;
    if (req_a[0] !== 1'b0 || st_a[0] !== S_IDLE || data_a[0] !== '0 ||
        ws0 !== 16'd0 || a_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid req=%b state=%0d data=%h ws=%0d a=%b want 0 0 0 0 0",
               req_a[0], st_a[0], data_a[0], ws0, a_a[0]);
    end
    sync_clk();
    rst_a[0]     = 1'b1;
    ws_exp[0]    = 0;
    chip_auto[0] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    ack_dly[0] = 2;
    run_words(0, 8, 1'b0, 2, "back_to_back");
    run_words(0, 24, 1'b1, 2, "random");
    ack_dly[1] = 1;
    run_words(1, 17, 1'b1, 5, "setup5_wrap");
    ack_dly[0] = 3;
    test_preset_hold();
    test_preset_setup();
    test_preset_req();
    test_meta();
    test_stale_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
